// File: rtl/rv_run_controller.sv
// Run/reset controller for the single-cycle RISC-V core: stretches reset release,
// gates core progress with a registered clock enable (free-run or single-step),
// counts enabled cycles and halts on timeout, PC self-loop or halt address.
// Latency: every output is registered; inputs sampled at edge N act from cycle N+1.
// Backpressure: none; step requests are edge-detected, a held request yields one step.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   run_en_i       1 = free run, 0 = step mode
//   step_req_i     step request (rising edge grants one enabled cycle)
//   clr_req_i      synchronous restart request (highest synchronous priority)
//   pc_i           current core PC
//   core_rst_n_o   core reset, active-low
//   core_clk_en_o  core enable; the core advances only when 1
//   cycle_count_o  enabled cycles since last reset/restart (saturating)
//   halted_o       core stopped by a halt condition
//   halt_cause_o   00 none, 01 timeout, 10 PC self-loop, 11 halt address
module rv_run_controller #(
  parameter int                XLEN        = 32,
  parameter int                CNT_W       = 32,
  parameter int                RST_CYCLES  = 4,
  parameter int                MAX_CYCLES  = 20,
  parameter int                LOOP_CYCLES = 3,
  parameter logic [XLEN-1:0]   HALT_ADDR   = 32'hFFFF_FFFC
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_en_i,
  input  logic             step_req_i,
  input  logic             clr_req_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             core_rst_n_o,
  output logic             core_clk_en_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             halted_o,
  output logic [1:0]       halt_cause_o
);

  // The hold counter only needs to reach RST_CYCLES-1; the loop counter LOOP_CYCLES-1.
  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int LW = (LOOP_CYCLES > 1) ? $clog2(LOOP_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [LW:0]   LOOP_L    = (LW + 1)'(LOOP_CYCLES);
  localparam logic [CNT_W:0] MAX_L    = (CNT_W + 1)'(MAX_CYCLES);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_TO   = 2'b01;
  localparam logic [1:0] CAUSE_LOOP = 2'b10;
  localparam logic [1:0] CAUSE_ADDR = 2'b11;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_STEP,
    S_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             clk_en_q, clk_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic [1:0]       cause_q, cause_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [LW-1:0]    loop_cnt_q, loop_cnt_d;
  logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
  logic             prev_vld_q, prev_vld_d;
  logic             step_prev_q, step_prev_d;

  logic [CNT_W:0]   cnt_nxt;
  logic [LW:0]      loop_nxt;
  logic             pc_same;
  logic             hit_addr;
  logic             hit_loop;
  logic             hit_to;
  logic             step_edge;

  // One extra bit catches the wrap so the counter can saturate.
  assign cnt_nxt   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign loop_nxt  = {1'b0, loop_cnt_q} + {{LW{1'b0}}, 1'b1};
  assign pc_same   = prev_vld_q && (pc_i == prev_pc_q);
  assign hit_addr  = (pc_i == HALT_ADDR);
  // loop_cnt_q holds the repeats already seen; this cycle's repeat completes the run.
  assign hit_loop  = (LOOP_CYCLES != 0) && pc_same && (loop_nxt == LOOP_L);
  assign hit_to    = (MAX_CYCLES != 0) && (cnt_nxt == MAX_L);
  assign step_edge = step_req_i && !step_prev_q;

  always_comb begin
    state_d      = state_q;
    core_rst_n_d = core_rst_n_q;
    clk_en_d     = clk_en_q;
    cnt_d        = cnt_q;
    halted_d     = halted_q;
    cause_d      = cause_q;
    hold_cnt_d   = hold_cnt_q;
    loop_cnt_d   = loop_cnt_q;
    prev_pc_d    = prev_pc_q;
    prev_vld_d   = prev_vld_q;
    step_prev_d  = step_req_i;

    if (clr_req_i) begin
      state_d      = S_HOLD;
      core_rst_n_d = 1'b0;
      clk_en_d     = 1'b0;
      cnt_d        = '0;
      halted_d     = 1'b0;
      cause_d      = CAUSE_NONE;
      hold_cnt_d   = '0;
      loop_cnt_d   = '0;
      prev_vld_d   = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d      = run_en_i ? S_RUN : S_STEP;
            core_rst_n_d = 1'b1;
            clk_en_d     = run_en_i;
            hold_cnt_d   = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
        S_RUN, S_STEP: begin
          // Bookkeeping for the cycle that just executed on the core.
          if (clk_en_q) begin
            cnt_d      = cnt_nxt[CNT_W] ? cnt_q : cnt_nxt[CNT_W-1:0];
            prev_pc_d  = pc_i;
            prev_vld_d = 1'b1;
            loop_cnt_d = pc_same ? loop_nxt[LW-1:0] : '0;
          end
          if (clk_en_q && (hit_addr || hit_loop || hit_to)) begin
            state_d  = S_HALTED;
            clk_en_d = 1'b0;
            halted_d = 1'b1;
            cause_d  = hit_addr ? CAUSE_ADDR : (hit_loop ? CAUSE_LOOP : CAUSE_TO);
          end else if (run_en_i) begin
            state_d  = S_RUN;
            clk_en_d = 1'b1;
          end else begin
            state_d  = S_STEP;
            clk_en_d = step_edge;
          end
        end
        S_HALTED: begin
          clk_en_d = 1'b0;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_HOLD;
      core_rst_n_q <= 1'b0;
      clk_en_q     <= 1'b0;
      cnt_q        <= '0;
      halted_q     <= 1'b0;
      cause_q      <= CAUSE_NONE;
      hold_cnt_q   <= '0;
      loop_cnt_q   <= '0;
      prev_pc_q    <= '0;
      prev_vld_q   <= 1'b0;
      step_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_rst_n_q <= core_rst_n_d;
      clk_en_q     <= clk_en_d;
      cnt_q        <= cnt_d;
      halted_q     <= halted_d;
      cause_q      <= cause_d;
      hold_cnt_q   <= hold_cnt_d;
      loop_cnt_q   <= loop_cnt_d;
      prev_pc_q    <= prev_pc_d;
      prev_vld_q   <= prev_vld_d;
      step_prev_q  <= step_prev_d;
    end
  end

  assign core_rst_n_o  = core_rst_n_q;
  assign core_clk_en_o = clk_en_q;
  assign cycle_count_o = cnt_q;
  assign halted_o      = halted_q;
  assign halt_cause_o  = cause_q;

endmodule

// File: tb/tb_rv_run_controller.sv
// Bench for rv_run_controller: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model (edge counts, PC history queue,
// plain arithmetic on the cycle count), with literal spot checks on key values.
module tb_rv_run_controller;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 32;
  localparam int          RSTC  = 4;
  localparam int          MAXC  = 20;
  localparam int          LOOPC = 3;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFC;

  logic             clk;
  logic             rst_n;
  logic             run_en;
  logic             step_req;
  logic             clr_req;
  logic [XLEN-1:0]  pc;
  logic             core_rst_n;
  logic             core_clk_en;
  logic [CNT_W-1:0] cycle_count;
  logic             halted;
  logic [1:0]       halt_cause;

  rv_run_controller #(
    .XLEN(XLEN), .CNT_W(CNT_W), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
    .LOOP_CYCLES(LOOPC), .HALT_ADDR(HALT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_en_i(run_en), .step_req_i(step_req),
    .clr_req_i(clr_req), .pc_i(pc), .core_rst_n_o(core_rst_n),
    .core_clk_en_o(core_clk_en), .cycle_count_o(cycle_count),
    .halted_o(halted), .halt_cause_o(halt_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state.
  bit           m_rst_n, m_en, m_halted, m_step_prev;
  bit [1:0]     m_cause;
  longint       m_cnt;
  int           m_hold_clocks;
  logic [31:0]  pcs[$];
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  task automatic model_reset();
    m_rst_n = 0; m_en = 0; m_halted = 0; m_cause = 0; m_cnt = 0;
    m_hold_clocks = 0; m_step_prev = 0; pcs.delete();
  endtask

  // Self-loop: the last LOOPC+1 enabled-cycle PCs are all the same value.
  function automatic bit loop_seen();
    if (LOOPC == 0 || pcs.size() < LOOPC + 1) return 0;
    for (int i = pcs.size() - LOOPC; i < pcs.size(); i++)
      if (pcs[i] != pcs[pcs.size() - LOOPC - 1]) return 0;
    return 1;
  endfunction

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit pulse;
    bit [1:0] c;
    if (!rst_n) begin
      m_step_prev = 0;
      return;
    end
    pulse = step_req && !m_step_prev;
    m_step_prev = step_req;
    if (clr_req) begin
      model_reset();
      m_step_prev = step_req;
      return;
    end
    if (!m_rst_n) begin
      m_hold_clocks++;
      if (m_hold_clocks == RSTC) begin
        m_rst_n = 1;
        m_en = run_en;
      end
      return;
    end
    if (m_halted) return;
    if (m_en) begin
      pcs.push_back(pc);
      if (pcs.size() > LOOPC + 1) void'(pcs.pop_front());
      c = 2'b00;
      if (pc == HALT) c = 2'b11;
      else if (loop_seen()) c = 2'b10;
      else if (MAXC != 0 && m_cnt + 1 == MAXC) c = 2'b01;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (c != 2'b00) begin
        m_halted = 1; m_cause = c; m_en = 0;
        return;
      end
    end
    m_en = run_en ? 1'b1 : pulse;
  endtask

  task automatic compare_all();
    vectors++;
    if (core_rst_n !== m_rst_n || core_clk_en !== m_en || halted !== m_halted ||
        halt_cause !== m_cause || cycle_count !== CNT_W'(m_cnt)) begin
      miscompares++;
      $display("FAIL model t=%0t: dut rst_n=%b en=%b cnt=%0d halted=%b cause=%b, expected rst_n=%b en=%b cnt=%0d halted=%b cause=%b",
               $time, core_rst_n, core_clk_en, cycle_count, halted, halt_cause,
               m_rst_n, m_en, m_cnt, m_halted, m_cause);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_clr();
    clr_req = 1; tick(); clr_req = 0;
  endtask

  int en_seen;
  int pc_ctr;
  bit pc_inc_mode;

  initial begin
    rst_n = 0; run_en = 1; step_req = 0; clr_req = 0; pc = '0;
    model_reset();

    // Release: two clocks in reset, release between edges, 4 edges of hold.
    repeat (2) tick();
    check("reset_rst_n", 32'(core_rst_n), 0);
    check("reset_cnt", cycle_count, 0);
    rst_n = 1;
    for (int i = 1; i <= RSTC; i++) begin
      tick();
      check($sformatf("release_rst_n_edge%0d", i), 32'(core_rst_n), (i == RSTC) ? 1 : 0);
    end
    check("release_en", 32'(core_clk_en), 1);

    // Timeout: PC advances by 4 on every enabled cycle.
    for (int i = 0; i < 60 && !halted; i++) begin
      pc = 32'(4 * m_cnt);
      tick();
    end
    check("to_halted", 32'(halted), 1);
    check("to_cause", 32'(halt_cause), 1);
    check("to_count", cycle_count, 20);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("to_en_stays_0", 32'(core_clk_en), 0);
    end

    // Self-loop: PC stuck at 0x40 from enabled cycle 5.
    do_clr();
    check("clr_rst_n", 32'(core_rst_n), 0);
    check("clr_cnt", cycle_count, 0);
    check("clr_halted", 32'(halted), 0);
    for (int i = 0; i < 80 && !halted; i++) begin
      pc = (m_cnt >= 4) ? 32'h40 : 32'(4 * m_cnt);
      tick();
    end
    check("loop_cause", 32'(halt_cause), 2);
    check("loop_count", cycle_count, 8);
    repeat (5) tick();
    check("loop_count_frozen", cycle_count, 8);

    // Step mode: three single-clock pulses and one five-clock pulse.
    run_en = 0;
    do_clr();
    pc_ctr = 64;
    repeat (RSTC + 1) begin pc = 32'(pc_ctr++ * 4); tick(); end
    en_seen = 0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < ((p == 3) ? 5 : 1); k++) begin
        step_req = 1; pc = 32'(pc_ctr++ * 4); tick();
        en_seen += int'(core_clk_en);
      end
      for (int k = 0; k < 3; k++) begin
        step_req = 0; pc = 32'(pc_ctr++ * 4); tick();
        en_seen += int'(core_clk_en);
      end
    end
    check("step_en_cycles", 32'(en_seen), 4);
    check("step_count", cycle_count, 4);

    // Halt address coinciding with timeout.
    run_en = 1;
    do_clr();
    for (int i = 0; i < 80 && !halted; i++) begin
      pc = (m_cnt == 19) ? HALT : 32'(4 * m_cnt);
      tick();
    end
    check("simul_cause", 32'(halt_cause), 3);
    check("simul_count", cycle_count, 20);

    // Restart from HALTED, then asynchronous reset mid-RUN.
    do_clr();
    check("restart_rst_n", 32'(core_rst_n), 0);
    for (int i = 0; i < RSTC; i++) begin pc = 32'(4 * m_cnt); tick(); end
    check("restart_en", 32'(core_clk_en), 1);
    repeat (5) begin pc = 32'(4 * m_cnt); tick(); end
    #2 rst_n = 0;
    model_reset();
    #1;
    check("arst_rst_n", 32'(core_rst_n), 0);
    check("arst_en", 32'(core_clk_en), 0);
    check("arst_cnt", cycle_count, 0);
    check("arst_halted", 32'(halted), 0);
    tick();
    rst_n = 1;

    // Randomized traffic.
    pc_inc_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) run_en = ~run_en;
      if ($urandom_range(0, 31) == 0) pc_inc_mode = ~pc_inc_mode;
      step_req = ($urandom_range(0, 2) == 0);
      clr_req  = ($urandom_range(0, 39) == 0);
      if (pc_inc_mode) begin
        pc = 32'(4 * m_cnt);
      end else begin
        case ($urandom_range(0, 99)) inside
          [0:2]:   pc = HALT;
          [3:54]:  pc = pc;
          default: pc = 32'($urandom_range(0, 15)) << 2;
        endcase
      end
      if ($urandom_range(0, 249) == 0) begin
        #2 rst_n = 0;
        model_reset();
        tick();
        rst_n = 1;
      end else begin
        tick();
      end
    end
    clr_req = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
